button_event_decoder: RTL and testbench

Input-side conditioning block for a raw push button. It turns the button signal into clean, single-cycle event pulses that the LED control logic consumes. It sits between the inverted key pin (active high) and led_ctrl. Processing chain: synchroniser, debouncer, press classifier (press, release, short, long and, optionally, double click).

---
 rtl/button_event_decoder.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_button_event_decoder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// button_event_decoder
// Conditions a raw, active-high push button into a clean debounced level and
// single-cycle event pulses for the LED control logic.
// Chain: two-flop synchroniser -> stability debouncer -> press classifier.
// The classifier reports press, release, short click and long hold. Defining
// the macro DOUBLE_CLICK_EN also enables double-click detection. In that build
// the short-click report waits until the gap window closes without a second
// press.
// Without DOUBLE_CLICK_EN, double_pulse is tied low and GAP_CYC has no effect.

module button_event_decoder #(
   parameter int unsigned DEBOUNCE_CYC = 1000000,
   parameter int unsigned LONG_CYC     = 50000000,
   parameter int unsigned GAP_CYC      = 15000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic short_pulse,
   output logic long_pulse,
   output logic long_hold,
   output logic double_pulse
);

   // Counter widths hold the largest value each counter is allowed to reach.
   localparam int unsigned DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int unsigned HOLD_W = $clog2(LONG_CYC);

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 2);

`ifdef DOUBLE_CLICK_EN
   localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYC - 1);
`endif

   // Reject parameter sets the counters and the classifier cannot honour.
   if (DEBOUNCE_CYC < 2 || LONG_CYC <= DEBOUNCE_CYC || GAP_CYC == 0) begin : g_param_check
      $error("button_event_decoder: DEBOUNCE_CYC >= 2, LONG_CYC > DEBOUNCE_CYC and GAP_CYC > 0 required");
   end

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PRESSED  = 3'd1,
      LONG     = 3'd2
`ifdef DOUBLE_CLICK_EN
      ,
      GAP_WAIT = 3'd3,
      PRESSED2 = 3'd4
`endif
   } state_t;

   state_t state;
   state_t state_next;

   logic sync_meta;
   logic btn_sync;
   logic [DEB_W-1:0] deb_cnt;
   logic deb_diff;
   logic deb_done;
   logic rise;
   logic fall;

   logic [HOLD_W-1:0] hold_cnt;
   logic hold_long;
   logic holding;

   logic press_next;
   logic release_next;
   logic short_next;
   logic long_next;
   logic long_hold_next;

`ifdef DOUBLE_CLICK_EN
   logic [GAP_W-1:0] gap_cnt;
   logic gap_done;
   logic double_next;
`endif

   // Two-flop synchroniser that brings the asynchronous button into the clk domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= 1'b0;
         btn_sync  <= 1'b0;
      end else begin
         sync_meta <= btn_raw;
         btn_sync  <= sync_meta;
      end
   end

   // A level change is accepted only after DEBOUNCE_CYC consecutive differing samples.
   // The same condition also serves as the rise and fall event seen by the classifier.
   assign deb_diff = btn_sync ^ btn_level;
   assign deb_done = deb_diff && (deb_cnt == DEB_LAST);
   assign rise     = deb_done & ~btn_level;
   assign fall     = deb_done & btn_level;

   // Debouncer: count while the input disagrees with the level and restart on any agreement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_cnt   <= '0;
         btn_level <= 1'b0;
      end else if (!deb_diff) begin
         deb_cnt <= '0;
      end else if (deb_done) begin
         deb_cnt   <= '0;
         btn_level <= ~btn_level;
      end else begin
         deb_cnt <= deb_cnt + 1'b1;
      end
   end

   // hold_cnt holds the number of cycles since the press edge minus one. The long
   // transition fires on the edge where the counter is written with LONG_CYC-1.
   assign hold_long = (hold_cnt == HOLD_LAST);

`ifdef DOUBLE_CLICK_EN
   assign holding  = (state == PRESSED) || (state == PRESSED2);
   assign gap_done = (gap_cnt == GAP_MAX);
`else
   assign holding  = (state == PRESSED);
`endif

   // Hold counter: restart on every accepted press and saturate instead of wrapping.
   // The counter stays frozen outside the pressed states.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
      end else if (rise) begin
         hold_cnt <= '0;
      end else if (holding && (hold_cnt != HOLD_MAX)) begin
         hold_cnt <= hold_cnt + 1'b1;
      end
   end

`ifdef DOUBLE_CLICK_EN
   // Gap counter: starts at a short release and saturates. The window closes once the
   // counter has spent a full cycle at GAP_CYC-1, which makes the window GAP_CYC cycles long.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_cnt <= '0;
      end else if ((state == PRESSED) && fall) begin
         gap_cnt <= '0;
      end else if ((state == GAP_WAIT) && !gap_done) begin
         gap_cnt <= gap_cnt + 1'b1;
      end
   end
`endif

   // Classifier state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Classifier next state. A release always wins over a long hold that matures on the same cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (rise) begin
               state_next = PRESSED;
            end
         end
         PRESSED: begin
            if (fall) begin
`ifdef DOUBLE_CLICK_EN
               state_next = GAP_WAIT;
`else
               state_next = IDLE;
`endif
            end else if (hold_long) begin
               state_next = LONG;
            end
         end
         LONG: begin
            if (fall) begin
               state_next = IDLE;
            end
         end
`ifdef DOUBLE_CLICK_EN
         GAP_WAIT: begin
            if (rise) begin
               state_next = PRESSED2;
            end else if (gap_done) begin
               state_next = IDLE;
            end
         end
         PRESSED2: begin
            if (fall) begin
               state_next = IDLE;
            end else if (hold_long) begin
               state_next = LONG;
            end
         end
`endif
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Event decode: each pulse is raised for the transition that is about to happen.
   always_comb begin
      press_next   = 1'b0;
      release_next = 1'b0;
      short_next   = 1'b0;
      long_next    = 1'b0;
`ifdef DOUBLE_CLICK_EN
      double_next  = 1'b0;
`endif
      case (state)
         IDLE: begin
            press_next = rise;
         end
         PRESSED: begin
            release_next = fall;
`ifndef DOUBLE_CLICK_EN
            short_next   = fall;
`endif
            long_next    = ~fall & hold_long;
         end
         LONG: begin
            release_next = fall;
         end
`ifdef DOUBLE_CLICK_EN
         GAP_WAIT: begin
            press_next = rise;
            short_next = ~rise & gap_done;
         end
         PRESSED2: begin
            release_next = fall;
            double_next  = fall;
            short_next   = ~fall & hold_long;
            long_next    = ~fall & hold_long;
         end
`endif
         default: begin
         end
      endcase
      long_hold_next = (state_next == LONG);
   end

   // Registered event outputs, so that every pulse lasts exactly one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         short_pulse   <= 1'b0;
         long_pulse    <= 1'b0;
         long_hold     <= 1'b0;
      end else begin
         press_pulse   <= press_next;
         release_pulse <= release_next;
         short_pulse   <= short_next;
         long_pulse    <= long_next;
         long_hold     <= long_hold_next;
      end
   end

`ifdef DOUBLE_CLICK_EN
   // Registered double-click pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         double_pulse <= 1'b0;
      end else begin
         double_pulse <= double_next;
      end
   end
`else
   assign double_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Testbench for button_event_decoder.
// A timeline reference model runs alongside the DUT and checks it on every cycle.
// The model decides the debounced level from a sliding window of synchronised samples.
// It classifies presses from the timestamps of the press and release edges.
// Directed scenarios add absolute latency checks. A randomized phase follows them.

module tb_button_event_decoder;

   localparam int DEB = 4;
   localparam int LNG = 20;
   localparam int GAP = 10;

   logic clk;
   logic rst_n;
   logic btn_raw;
   logic btn_level;
   logic press_pulse;
   logic release_pulse;
   logic short_pulse;
   logic long_pulse;
   logic long_hold;
   logic double_pulse;

   button_event_decoder #(
      .DEBOUNCE_CYC(DEB),
      .LONG_CYC(LNG),
      .GAP_CYC(GAP)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn_raw(btn_raw),
      .btn_level(btn_level),
      .press_pulse(press_pulse),
      .release_pulse(release_pulse),
      .short_pulse(short_pulse),
      .long_pulse(long_pulse),
      .long_hold(long_hold),
      .double_pulse(double_pulse)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Reference model state.
   typedef enum {M_IDLE, M_HELD, M_LONG, M_WAIT, M_HELD2} mphase_t;
   mphase_t m_phase;
   logic m_s1, m_s2, m_level;
   logic win[$];
   int m_t_press, m_t_release;
   logic e_press, e_release, e_short, e_long, e_hold, e_double;

   // Event statistics observed on the DUT outputs.
   int d_n_press, d_n_release, d_n_short, d_n_long, d_n_double, d_n_hold, d_n_level;
   int d_t_press, d_t_release, d_t_short, d_t_long, d_t_double;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   task automatic modelReset();
      m_phase = M_IDLE;
      m_s1 = 1'b0;
      m_s2 = 1'b0;
      m_level = 1'b0;
      win.delete();
      m_t_press = 0;
      m_t_release = 0;
      e_press = 1'b0; e_release = 1'b0; e_short = 1'b0;
      e_long = 1'b0; e_hold = 1'b0; e_double = 1'b0;
   endtask

   task automatic clearStats();
      d_n_press = 0; d_n_release = 0; d_n_short = 0; d_n_long = 0;
      d_n_double = 0; d_n_hold = 0; d_n_level = 0;
      d_t_press = -1; d_t_release = -1; d_t_short = -1; d_t_long = -1; d_t_double = -1;
   endtask

   // One clock edge of the model. The value raw is the button level sampled at this edge.
   task automatic modelStep(input logic raw);
      logic seen, toggle, ev_rise, ev_fall;
      int held_for;
      seen = m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      win.push_back(seen);
      if (win.size() > DEB) void'(win.pop_front());
      toggle = (win.size() == DEB);
      foreach (win[i]) if (win[i] == m_level) toggle = 1'b0;
      ev_rise = toggle & ~m_level;
      ev_fall = toggle & m_level;
      if (toggle) begin
         m_level = ~m_level;
         win.delete();
      end
      e_press = 1'b0; e_release = 1'b0; e_short = 1'b0; e_long = 1'b0; e_double = 1'b0;
      held_for = cyc - m_t_press;
      case (m_phase)
         M_IDLE: if (ev_rise) begin
            m_phase = M_HELD; m_t_press = cyc; e_press = 1'b1;
         end
         M_HELD: if (ev_fall) begin
            e_release = 1'b1;
`ifdef DOUBLE_CLICK_EN
            m_phase = M_WAIT; m_t_release = cyc;
`else
            m_phase = M_IDLE; e_short = 1'b1;
`endif
         end else if (held_for == LNG - 1) begin
            m_phase = M_LONG; e_long = 1'b1;
         end
         M_LONG: if (ev_fall) begin
            m_phase = M_IDLE; e_release = 1'b1;
         end
         M_WAIT: if (ev_rise) begin
            m_phase = M_HELD2; m_t_press = cyc; e_press = 1'b1;
         end else if (cyc - m_t_release == GAP) begin
            m_phase = M_IDLE; e_short = 1'b1;
         end
         M_HELD2: if (ev_fall) begin
            m_phase = M_IDLE; e_release = 1'b1; e_double = 1'b1;
         end else if (held_for == LNG - 1) begin
            m_phase = M_LONG; e_short = 1'b1; e_long = 1'b1;
         end
         default: m_phase = M_IDLE;
      endcase
      e_hold = (m_phase == M_LONG);
   endtask

   // Compare every output with the model and update the observed event statistics.
   task automatic compareAll();
      checkOutput("btn_level", btn_level, m_level);
      checkOutput("press_pulse", press_pulse, e_press);
      checkOutput("release_pulse", release_pulse, e_release);
      checkOutput("short_pulse", short_pulse, e_short);
      checkOutput("long_pulse", long_pulse, e_long);
      checkOutput("long_hold", long_hold, e_hold);
      checkOutput("double_pulse", double_pulse, e_double);
      if (press_pulse === 1'b1) begin d_n_press++; d_t_press = cyc; end
      if (release_pulse === 1'b1) begin d_n_release++; d_t_release = cyc; end
      if (short_pulse === 1'b1) begin d_n_short++; d_t_short = cyc; end
      if (long_pulse === 1'b1) begin d_n_long++; d_t_long = cyc; end
      if (double_pulse === 1'b1) begin d_n_double++; d_t_double = cyc; end
      if (long_hold === 1'b1) d_n_hold++;
      if (btn_level === 1'b1) d_n_level++;
   endtask

   // Drive raw for ncyc clock edges. The task is entered and left at a falling edge.
   task automatic applyStimulus(input logic raw, input int ncyc);
      repeat (ncyc) begin
         btn_raw = raw;
         @(posedge clk);
         cyc++;
         modelStep(raw);
         @(negedge clk);
         compareAll();
      end
   endtask

   // Assert reset mid-cycle, check the immediate clear, hold it, then release it.
   task automatic pulseReset(input int ncyc);
      rst_n = 1'b0;
      #1;
      modelReset();
      compareAll();
      repeat (ncyc) begin
         @(negedge clk);
         compareAll();
      end
      rst_n = 1'b1;
   endtask

   int rise_ref, fall_ref;
   logic lvl;

   initial begin
      rst_n = 1'b0;
      btn_raw = 1'b0;
      modelReset();
      clearStats();

      // 1: reset state, then a glitch shorter than the debounce time.
      repeat (2) begin
         @(negedge clk);
         compareAll();
      end
      rst_n = 1'b1;
      applyStimulus(1'b0, 5);
      clearStats();
      applyStimulus(1'b1, 3);
      applyStimulus(1'b0, 10);
      checkOutput("glitch_presses", d_n_press, 0);
      checkOutput("glitch_level", d_n_level, 0);

      // 2: short click.
      clearStats();
      rise_ref = cyc;
      applyStimulus(1'b1, 10);
      fall_ref = cyc;
      applyStimulus(1'b0, 25);
      checkOutput("short_press_lat", d_t_press - rise_ref, 6);
      checkOutput("short_release_lat", d_t_release - fall_ref, 6);
      checkOutput("short_count", d_n_short, 1);
      checkOutput("short_no_long", d_n_long, 0);
`ifdef DOUBLE_CLICK_EN
      checkOutput("short_deferred_lat", d_t_short - fall_ref, 16);
`else
      checkOutput("short_with_release", d_t_short - fall_ref, 6);
`endif

      // 3: long hold.
      clearStats();
      rise_ref = cyc;
      applyStimulus(1'b1, 40);
      applyStimulus(1'b0, 20);
      checkOutput("long_after_press", d_t_long - d_t_press, 19);
      checkOutput("long_count", d_n_long, 1);
      checkOutput("long_hold_cycles", d_n_hold, 21);
      checkOutput("long_release_lat", d_t_release - rise_ref, 46);
      checkOutput("long_no_short", d_n_short, 0);
      checkOutput("long_hold_end", long_hold, 1'b0);

`ifdef DOUBLE_CLICK_EN
      // 4: double click.
      clearStats();
      rise_ref = cyc;
      applyStimulus(1'b1, 8);
      applyStimulus(1'b0, 6);
      applyStimulus(1'b1, 8);
      applyStimulus(1'b0, 25);
      checkOutput("dbl_presses", d_n_press, 2);
      checkOutput("dbl_releases", d_n_release, 2);
      checkOutput("dbl_count", d_n_double, 1);
      checkOutput("dbl_time", d_t_double - rise_ref, 28);
      checkOutput("dbl_no_short", d_n_short, 0);

      // 5: a short click followed by a long second press.
      clearStats();
      rise_ref = cyc;
      applyStimulus(1'b1, 8);
      applyStimulus(1'b0, 6);
      applyStimulus(1'b1, 30);
      applyStimulus(1'b0, 20);
      checkOutput("sl_long_after_press2", d_t_long - d_t_press, 19);
      checkOutput("sl_long_time", d_t_long - rise_ref, 39);
      checkOutput("sl_short_time", d_t_short - rise_ref, 39);
      checkOutput("sl_no_double", d_n_double, 0);

      // 6b: a reset in GAP_WAIT discards the deferred short pulse.
      applyStimulus(1'b1, 8);
      applyStimulus(1'b0, 8);
      pulseReset(2);
      clearStats();
      applyStimulus(1'b0, 20);
      checkOutput("gap_reset_no_short", d_n_short, 0);
`endif

      // 6: reset while pressed, with the button still held through the reset.
      applyStimulus(1'b1, 10);
      pulseReset(2);
      clearStats();
      rise_ref = cyc;
      applyStimulus(1'b1, 10);
      checkOutput("rst_press_lat", d_t_press - rise_ref, 6);
      checkOutput("rst_no_release", d_n_release, 0);
      checkOutput("rst_no_short", d_n_short, 0);
      applyStimulus(1'b0, 30);

      // Randomized phase: mixed glitches, clicks, holds and occasional resets.
      lvl = 1'b1;
      for (int s = 0; s < 60; s++) begin
         int kind;
         int len;
         kind = int'($urandom_range(0, 3));
         case (kind)
            0: len = int'($urandom_range(1, 3));
            1: len = int'($urandom_range(5, 12));
            2: len = int'($urandom_range(15, 35));
            default: len = int'($urandom_range(3, 14));
         endcase
         applyStimulus(lvl, len);
         lvl = ~lvl;
         if ($urandom_range(0, 14) == 0) begin
            btn_raw = 1'($urandom_range(0, 1));
            pulseReset(2);
         end
      end
      applyStimulus(1'b0, 40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
